// File: rtl/blk_rd_engine.sv
// Block read engine: reads one cache block per request from SRAM, extracts the
// packet length from the header word and streams the words out with SOP/EOP.
module blk_rd_engine #(
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 10,
    parameter int TIMES_WIDTH    = 4,
    parameter int BUF_DEPTH      = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [BLK_ADDR_WIDTH-1:0]         i_blk_addr,
    input  logic                              i_blk_addr_vld,
    input  logic                              i_last_blk_vld,
    input  logic [TIMES_WIDTH-1:0]            i_last_r_times,
    output logic                              o_sram_rd_en,
    output logic [BLK_ADDR_WIDTH+TIMES_WIDTH-1:0] o_sram_rd_addr,
    input  logic [DATA_WIDTH-1:0]             i_sram_rd_data,
    output logic [LEN_WIDTH-1:0]              o_len,
    output logic                              o_len_vld,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic                              o_data_vld,
    input  logic                              i_out_rdy,
    output logic                              o_sop,
    output logic                              o_eop,
    output logic                              o_r_done
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state;
    logic [BLK_ADDR_WIDTH-1:0] blk_q;
    logic                      is_last_q;
    logic [TIMES_WIDTH-1:0]    last_idx_q;
    logic [TIMES_WIDTH-1:0]    word_idx;
    logic                      pkt_start;
    logic                      tag_sop_q;
    logic                      tag_eop_q;
    logic                      rd_en_d;
    logic                      tag_sop_d;
    logic                      tag_eop_d;

    logic [DATA_WIDTH-1:0]     data_mem [BUF_DEPTH];
    logic                      sop_mem  [BUF_DEPTH];
    logic                      eop_mem  [BUF_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    logic                      push;
    logic                      pop;
    logic [OCC_W-1:0]          occ;
    logic                      can_issue;
    logic                      final_pop;

    // Output handshake: a word moves when o_data_vld & i_out_rdy; while i_out_rdy
    // is low the head entry (o_data, o_sop, o_eop, o_data_vld) holds unchanged.
    assign o_data_vld = (count != '0);
    assign o_data     = data_mem[rd_ptr];
    assign o_sop      = o_data_vld & sop_mem[rd_ptr];
    assign o_eop      = o_data_vld & eop_mem[rd_ptr];

    assign push = rd_en_d;
    assign pop  = o_data_vld & i_out_rdy;

    // Buffered words plus both pipeline stages of reads still to land.
    assign occ = OCC_W'(count) + OCC_W'(o_sram_rd_en) + OCC_W'(rd_en_d) - OCC_W'(pop);
    assign can_issue = (occ < OCC_W'(BUF_DEPTH));
    assign final_pop = pop && (count == CNT_W'(1)) && !o_sram_rd_en && !rd_en_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            blk_q          <= '0;
            is_last_q      <= 1'b0;
            last_idx_q     <= '0;
            word_idx       <= '0;
            pkt_start      <= 1'b1;
            tag_sop_q      <= 1'b0;
            tag_eop_q      <= 1'b0;
            rd_en_d        <= 1'b0;
            tag_sop_d      <= 1'b0;
            tag_eop_d      <= 1'b0;
            o_sram_rd_en   <= 1'b0;
            o_sram_rd_addr <= '0;
            o_len          <= '0;
            o_len_vld      <= 1'b0;
            o_r_done       <= 1'b0;
        end else begin
            o_sram_rd_en <= 1'b0;
            o_r_done     <= 1'b0;
            rd_en_d      <= o_sram_rd_en;
            tag_sop_d    <= tag_sop_q;
            tag_eop_d    <= tag_eop_q;
            o_len_vld    <= rd_en_d & tag_sop_d;
            if (rd_en_d && tag_sop_d) begin
                o_len <= i_sram_rd_data[LEN_WIDTH-1:0];
            end
            if (pop && o_eop) begin
                pkt_start <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // Word 0 is issued on the accept edge so the read lands one cycle later.
                    if (i_blk_addr_vld) begin
                        blk_q          <= i_blk_addr;
                        is_last_q      <= i_last_blk_vld;
                        last_idx_q     <= i_last_blk_vld ? i_last_r_times : '1;
                        o_sram_rd_en   <= 1'b1;
                        o_sram_rd_addr <= {i_blk_addr, TIMES_WIDTH'(0)};
                        tag_sop_q      <= pkt_start;
                        tag_eop_q      <= i_last_blk_vld && (i_last_r_times == '0);
                        pkt_start      <= 1'b0;
                        word_idx       <= TIMES_WIDTH'(1);
                        if (i_last_blk_vld && (i_last_r_times == '0)) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (can_issue) begin
                        o_sram_rd_en   <= 1'b1;
                        o_sram_rd_addr <= {blk_q, word_idx};
                        tag_sop_q      <= 1'b0;
                        tag_eop_q      <= is_last_q && (word_idx == last_idx_q);
                        word_idx       <= word_idx + TIMES_WIDTH'(1);
                        if (word_idx == last_idx_q) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (final_pop) begin
                        o_r_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_mem[i] <= '0;
                sop_mem[i]  <= 1'b0;
                eop_mem[i]  <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= i_sram_rd_data;
                sop_mem[wr_ptr]  <= tag_sop_d;
                eop_mem[wr_ptr]  <= tag_eop_d;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_blk_rd_engine.sv
// Bench for blk_rd_engine: SRAM model, directed block requests, and monitors
// that pop expected reads, words and lengths from queues as the DUT presents them.
module tb_blk_rd_engine;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [9:0]  i_blk_addr = '0;
    logic        i_blk_addr_vld = 1'b0;
    logic        i_last_blk_vld = 1'b0;
    logic [3:0]  i_last_r_times = '0;
    logic        o_sram_rd_en;
    logic [13:0] o_sram_rd_addr;
    logic [31:0] i_sram_rd_data = '0;
    logic [9:0]  o_len;
    logic        o_len_vld;
    logic [31:0] o_data;
    logic        o_data_vld;
    logic        i_out_rdy = 1'b1;
    logic        o_sop;
    logic        o_eop;
    logic        o_r_done;

    blk_rd_engine dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_blk_addr     (i_blk_addr),
        .i_blk_addr_vld (i_blk_addr_vld),
        .i_last_blk_vld (i_last_blk_vld),
        .i_last_r_times (i_last_r_times),
        .o_sram_rd_en   (o_sram_rd_en),
        .o_sram_rd_addr (o_sram_rd_addr),
        .i_sram_rd_data (i_sram_rd_data),
        .o_len          (o_len),
        .o_len_vld      (o_len_vld),
        .o_data         (o_data),
        .o_data_vld     (o_data_vld),
        .i_out_rdy      (i_out_rdy),
        .o_sop          (o_sop),
        .o_eop          (o_eop),
        .o_r_done       (o_r_done)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [31:0] sram_mem [16384];
    always @(posedge i_clk) i_sram_rd_data <= o_sram_rd_en ? sram_mem[o_sram_rd_addr] : 32'h0;

    // scoreboard state
    logic [33:0] exp_q[$];
    logic [13:0] exp_addr_q[$];
    logic [9:0]  exp_len_q[$];
    int checks = 0;
    int errors = 0;
    int outstanding = 0;
    int xfer_cnt = 0, done_cnt = 0, len_cnt = 0, sop_cnt = 0, eop_cnt = 0;
    int done_cyc = 0, len_cyc = 0;
    logic tb_pkt_start = 1'b1;
    logic stall_prev = 1'b0;
    logic [34:0] stall_val = '0;
    logic bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    logic [1:0] bp_ph = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    always @(posedge i_clk) begin
        #1;
        if (bp_en) begin
            i_out_rdy = bp_pat[bp_ph];
            bp_ph = bp_ph + 2'd1;
        end else begin
            i_out_rdy = 1'b1;
        end
    end

    // monitor
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_sram_rd_en) begin
                if (exp_addr_q.size() == 0) fail_now("rd_addr_unexpected");
                else chk("rd_addr", 64'(o_sram_rd_addr), 64'(exp_addr_q.pop_front()));
                outstanding++;
            end
            if (o_data_vld && i_out_rdy) begin
                if (exp_q.size() == 0) fail_now("data_unexpected");
                else chk("data_sop_eop", {30'h0, o_sop, o_eop, o_data}, 64'(exp_q.pop_front()));
                outstanding--;
                xfer_cnt++;
                if (o_sop) sop_cnt++;
                if (o_eop) eop_cnt++;
            end
            if (o_sram_rd_en) chk("outstanding_le_depth", 64'(outstanding <= 4), 64'd1);
            if (o_len_vld) begin
                len_cnt++;
                len_cyc = cyc;
                if (exp_len_q.size() == 0) fail_now("len_unexpected");
                else chk("len", 64'(o_len), 64'(exp_len_q.pop_front()));
            end
            if (o_r_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall_prev) chk("stall_hold", 64'({o_data_vld, o_sop, o_eop, o_data}), 64'(stall_val));
            stall_prev = o_data_vld && !i_out_rdy;
            stall_val  = {o_data_vld, o_sop, o_eop, o_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // driver tasks
    task automatic start_blk(input logic [9:0] addr, input logic last, input logic [3:0] times,
                             output int t0);
        int n;
        n = last ? int'(times) + 1 : 16;
        for (int i = 0; i < n; i++) begin
            logic [13:0] a;
            logic [31:0] d;
            logic s, e;
            a = {addr, 4'(i)};
            d = sram_mem[a];
            s = tb_pkt_start && (i == 0);
            e = last && (i == n - 1);
            exp_addr_q.push_back(a);
            exp_q.push_back({s, e, d});
            if (s) exp_len_q.push_back(d[9:0]);
        end
        tb_pkt_start = last;
        @(posedge i_clk); #1;
        i_blk_addr = addr;
        i_last_blk_vld = last;
        i_last_r_times = times;
        i_blk_addr_vld = 1'b1;
        t0 = cyc;
        @(posedge i_clk); #1;
        i_blk_addr_vld = 1'b0;
        i_last_blk_vld = 1'b0;
    endtask

    task automatic wait_done(input int base, input int t0, input int lat);
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge i_clk); #1;
            if (done_cnt > base) break;
        end
        if (k == 300) fail_now("done_timeout");
        else if (lat > 0) chk("done_latency", 64'(done_cyc - t0), 64'(lat));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    initial begin
        int t0, b_done, b_len, b_sop, b_eop, b_xfer, k;
        for (int a = 0; a < 16384; a++) sram_mem[a] = {8'hC5, 10'h0, 14'(a)};
        sram_mem[14'h050] = 32'h0000_000A;
        sram_mem[14'h010] = 32'h0000_0030;
        sram_mem[14'h090] = 32'h0000_0010;
        sram_mem[14'h0C0] = 32'h0000_0008;
        sram_mem[14'h070] = 32'h0000_0015;
        sram_mem[14'h080] = 32'h0000_0022;
        sram_mem[14'h140] = 32'h0000_0001;
        sram_mem[14'h150] = 32'hABCD_E401;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_outputs", {2'b0, o_sram_rd_en, o_sram_rd_addr, o_len, o_len_vld, o_data,
                              o_data_vld, o_sop, o_eop, o_r_done}, 64'h0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        idle(2);

        // single-block packet: addr 5, 4 words, len 10
        b_done = done_cnt;
        start_blk(10'd5, 1'b1, 4'd3, t0);
        wait_done(b_done, t0, 7);
        chk("t1_len_latency", 64'(len_cyc - t0), 64'd3);
        idle(2);

        // three-block packet: 48 words, one SOP/EOP, len only on block 1
        b_len = len_cnt; b_sop = sop_cnt; b_eop = eop_cnt; b_xfer = xfer_cnt; b_done = done_cnt;
        start_blk(10'd1, 1'b0, 4'd0, t0);
        wait_done(b_done, t0, 19);
        start_blk(10'd2, 1'b0, 4'd0, t0);
        wait_done(b_done + 1, t0, 19);
        start_blk(10'd3, 1'b1, 4'd15, t0);
        wait_done(b_done + 2, t0, 19);
        idle(2);
        chk("t2_words", 64'(xfer_cnt - b_xfer), 64'd48);
        chk("t2_sop_count", 64'(sop_cnt - b_sop), 64'd1);
        chk("t2_eop_count", 64'(eop_cnt - b_eop), 64'd1);
        chk("t2_len_count", 64'(len_cnt - b_len), 64'd1);
        chk("t2_done_count", 64'(done_cnt - b_done), 64'd3);

        // back-pressure: ready pattern 1-0-0-1 over a 16-word block
        b_xfer = xfer_cnt; b_done = done_cnt;
        bp_en = 1'b1;
        start_blk(10'd9, 1'b1, 4'd15, t0);
        wait_done(b_done, t0, 0);
        bp_en = 1'b0;
        idle(3);
        chk("t3_words", 64'(xfer_cnt - b_xfer), 64'd16);
        chk("t3_done_count", 64'(done_cnt - b_done), 64'd1);

        // ignored strobe while reading
        b_done = done_cnt;
        start_blk(10'd12, 1'b1, 4'd7, t0);
        idle(1);
        i_blk_addr = 10'd13;
        i_last_blk_vld = 1'b1;
        i_blk_addr_vld = 1'b1;
        idle(1);
        i_blk_addr_vld = 1'b0;
        i_last_blk_vld = 1'b0;
        wait_done(b_done, t0, 0);
        idle(20);
        chk("t4_done_count", 64'(done_cnt - b_done), 64'd1);
        chk("t4_no_extra_reads", 64'(exp_addr_q.size()), 64'd0);

        // reset in the middle of a 16-word block
        b_xfer = xfer_cnt; b_done = done_cnt;
        start_blk(10'd7, 1'b1, 4'd15, t0);
        for (k = 0; k < 200; k++) begin
            if (xfer_cnt - b_xfer >= 5) break;
            @(posedge i_clk); #1;
        end
        if (k == 200) fail_now("t5_xfer_timeout");
        i_rst_n = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        exp_len_q.delete();
        outstanding = 0;
        tb_pkt_start = 1'b1;
        @(negedge i_clk);
        chk("t5_reset_outputs", {2'b0, o_sram_rd_en, o_sram_rd_addr, o_len, o_len_vld, o_data,
                                 o_data_vld, o_sop, o_eop, o_r_done}, 64'h0);
        idle(2);
        i_rst_n = 1'b1;
        idle(4);
        chk("t5_no_done", 64'(done_cnt - b_done), 64'd0);
        b_len = len_cnt; b_sop = sop_cnt; b_done = done_cnt;
        start_blk(10'd8, 1'b1, 4'd0, t0);
        wait_done(b_done, t0, 0);
        chk("t5_fresh_len", 64'(len_cnt - b_len), 64'd1);
        chk("t5_fresh_sop", 64'(sop_cnt - b_sop), 64'd1);
        idle(2);

        // back-to-back single-word packets
        b_len = len_cnt; b_sop = sop_cnt; b_eop = eop_cnt; b_done = done_cnt;
        start_blk(10'd20, 1'b1, 4'd0, t0);
        wait_done(b_done, t0, 0);
        start_blk(10'd21, 1'b1, 4'd0, t0);
        wait_done(b_done + 1, t0, 0);
        idle(3);
        chk("t6_len_count", 64'(len_cnt - b_len), 64'd2);
        chk("t6_sop_count", 64'(sop_cnt - b_sop), 64'd2);
        chk("t6_eop_count", 64'(eop_cnt - b_eop), 64'd2);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("exp_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        chk("exp_len_q_empty", 64'(exp_len_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench time limit reached");
    end

endmodule
